// File: rtl/mcu_spi_pkg.sv
// Shared constants and FSM encoding for the MCU SPI register bank.
// Optional feature macro: MCU_SPI_FRAME_CNT_EN (frame counter at ADDR_FCNT).
package mcu_spi_pkg;

  localparam logic [6:0] ADDR_DATE    = 7'h00;
  localparam logic [6:0] ADDR_VER     = 7'h01;
  localparam logic [6:0] ADDR_DIPSW   = 7'h02;
  localparam logic [6:0] ADDR_SCRATCH = 7'h03;
  localparam logic [6:0] ADDR_CTRL    = 7'h04;
  localparam logic [6:0] ADDR_FCNT    = 7'h05;

  localparam logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF;

  // Bit counter values on the last bit of each frame section.
  localparam logic [5:0] CNT_CMD_LAST  = 6'd7;
  localparam logic [5:0] CNT_DATA_LAST = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered rise/fall
// pulses; pin edge to pulse is three clk cycles.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic rise_d, rise_q;
  logic fall_d, fall_q;

  // Compare synchronized level against its previous value.
  always_comb begin
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  // Synchronizer chain and edge pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/mcu_spi_regbank.sv
// SPI mode-0 slave register bank for the MCU, oversampled in the clk domain.
// Frame: 8-bit command (R/W, addr[6:0]) then 32-bit data word, MSB first.
// Optional feature macro: MCU_SPI_FRAME_CNT_EN enables the frame counter.
module mcu_spi_regbank
  import mcu_spi_pkg::*;
#(
  parameter logic [31:0] SYN_DATE = 32'h1911_0100,
  parameter logic [7:0]  FPGA_VER = 8'h00,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_nss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [7:0]  dipsw,
  output logic [31:0] ctrl,
  output logic        wr_stb,
  output logic [6:0]  wr_addr,
  output logic [31:0] wr_data
);

  logic sck_rise, sck_fall, nss_rise, nss_fall;
  logic mosi_s1_q, mosi_s2_q;

  spi_sync_edge u_sck (.clk(clk), .rst_n(rst_n), .d(spi_sck), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge u_nss (.clk(clk), .rst_n(rst_n), .d(spi_nss), .rise(nss_rise), .fall(nss_fall));

  // MOSI needs only a synchronizer; it is stable around each SCK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  spi_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] scratch_q, scratch_d;
  logic        wr_stb_q, wr_stb_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
`ifdef MCU_SPI_FRAME_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
`endif

  logic [6:0]  cmd_addr;
  logic [31:0] rd_data;
  logic [31:0] shift_word;

  // Read mux, evaluated with the address completing on the 8th SCK rise.
  always_comb begin
    cmd_addr = {sr_q[5:0], mosi_s2_q};
    unique case (cmd_addr)
      ADDR_DATE:    rd_data = SYN_DATE;
      ADDR_VER:     rd_data = {24'h0, FPGA_VER};
      ADDR_DIPSW:   rd_data = {24'h0, dipsw};
      ADDR_SCRATCH: rd_data = scratch_q;
      ADDR_CTRL:    rd_data = ctrl_q;
`ifdef MCU_SPI_FRAME_CNT_EN
      ADDR_FCNT:    rd_data = fcnt_q;
`endif
      default:      rd_data = RD_DEFAULT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; NSS rising is applied after the SCK edge so a coincident last rise still completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (nss_fall) state_d = ST_CMD;
      ST_CMD:  if (sck_rise && cnt_q == CNT_CMD_LAST) state_d = ST_DATA;
      ST_DATA: if (sck_rise && cnt_q == CNT_DATA_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
    endcase
    if (nss_rise) state_d = ST_IDLE;
  end

  // Datapath: shifting, command latch, read load and write commit.
  always_comb begin
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    ctrl_d     = ctrl_q;
    scratch_d  = scratch_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef MCU_SPI_FRAME_CNT_EN
    fcnt_d     = fcnt_q;
`endif
    shift_word = {sr_q[30:0], mosi_s2_q};
    unique case (state_q)
      ST_IDLE: if (nss_fall) cnt_d = '0;
      ST_CMD: begin
        if (sck_rise) begin
          cnt_d = cnt_q + 6'd1;
          sr_d  = shift_word;
          if (cnt_q == CNT_CMD_LAST) begin
            cnt_d  = '0;
            rw_d   = sr_q[6];
            addr_d = cmd_addr;
            sr_d   = sr_q[6] ? rd_data : '0;
          end
        end
      end
      ST_DATA: begin
        if (sck_rise) begin
          cnt_d = cnt_q + 6'd1;
          if (!rw_q) sr_d = shift_word;
          if (cnt_q == CNT_DATA_LAST) begin
`ifdef MCU_SPI_FRAME_CNT_EN
            fcnt_d = fcnt_q + 32'd1;
`endif
            if (!rw_q) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = shift_word;
              if (addr_q == ADDR_SCRATCH) scratch_d = shift_word;
              if (addr_q == ADDR_CTRL)    ctrl_d    = shift_word;
            end
          end
        end else if (sck_fall && rw_q && cnt_q != '0) begin
          // The fall right after the command byte must keep bit 31 on the pin.
          sr_d = {sr_q[30:0], 1'b0};
        end
      end
      ST_DONE: cnt_d = cnt_q;
    endcase
  end

  // Datapath and register bank flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      sr_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      ctrl_q    <= CTRL_RST;
      scratch_q <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef MCU_SPI_FRAME_CNT_EN
      fcnt_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef MCU_SPI_FRAME_CNT_EN
      fcnt_q    <= fcnt_d;
`endif
    end
  end

  assign spi_miso = (state_q == ST_DATA && rw_q) ? sr_q[31] : 1'b0;
  assign ctrl     = ctrl_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_mcu_spi_regbank.sv
// Self-checking bench for mcu_spi_regbank: vector table, corner sequences
// and randomized frames checked against a register-map model.
module tb_mcu_spi_regbank;

  localparam logic [31:0] P_DATE = 32'h1911_0100;
  localparam logic [7:0]  P_VER  = 8'h00;
  localparam logic [31:0] P_CRST = 32'h0000_0000;
  localparam int unsigned HALF   = 8;
  localparam int unsigned NO_RST = 99;
`ifdef MCU_SPI_FRAME_CNT_EN
  localparam bit FCNT_EN = 1'b1;
`else
  localparam bit FCNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_nss = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [7:0]  dipsw = 8'h00;
  logic [31:0] ctrl;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;

  mcu_spi_regbank #(.SYN_DATE(P_DATE), .FPGA_VER(P_VER), .CTRL_RST(P_CRST)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_nss(spi_nss),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .dipsw(dipsw), .ctrl(ctrl),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Write strobe monitor.
  int          stb_cnt = 0;
  logic [6:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_cnt   = stb_cnt + 1;
      last_addr = wr_addr;
      last_data = wr_data;
    end
  end

  // Register map model.
  logic [31:0] m_ctrl = P_CRST;
  logic [31:0] m_scratch = '0;
  logic [31:0] m_fcnt = '0;

  function automatic logic [31:0] model_rd(input logic [6:0] a);
    case (a)
      7'h00:   return P_DATE;
      7'h01:   return {24'h0, P_VER};
      7'h02:   return {24'h0, dipsw};
      7'h03:   return m_scratch;
      7'h04:   return m_ctrl;
      7'h05:   return FCNT_EN ? m_fcnt : 32'hDEAD_BEEF;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic model_wr(input logic [6:0] a, input logic [31:0] d);
    if (a == 7'h03) m_scratch = d;
    if (a == 7'h04) m_ctrl = d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One SPI master frame; nbits < 40 gives a short frame, rst_bit pulses rst_n in that bit's high phase.
  task automatic spi_xfer(input bit rw, input logic [6:0] addr, input logic [31:0] wdata,
                          input int unsigned nbits, input int unsigned rst_bit,
                          input bit nss_with_last, output logic [31:0] rdata);
    logic [39:0] frame;
    frame = {rw, addr, wdata};
    rdata = '0;
    spi_nss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int unsigned i = 0; i < nbits; i++) begin
      spi_mosi = frame[39-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8) rdata = {rdata[30:0], spi_miso};
      spi_sck = 1'b1;
      if (nss_with_last && i == nbits - 1) spi_nss = 1'b1;
      if (i == rst_bit) begin
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_nss = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  typedef struct {
    bit          rw;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  dip;
    logic [31:0] exp_rd;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] rd;
    int          s0;

    vecs[0] = '{1'b1, 7'h00, 32'h0,         8'h00, 32'h1911_0100, 32'h0};
    vecs[1] = '{1'b0, 7'h04, 32'hA5A5_0F0F, 8'h00, 32'h0,         32'hA5A5_0F0F};
    vecs[2] = '{1'b1, 7'h04, 32'h0,         8'h00, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    vecs[3] = '{1'b1, 7'h01, 32'h0,         8'h00, 32'h0000_0000, 32'hA5A5_0F0F};
    vecs[4] = '{1'b1, 7'h02, 32'h0,         8'h81, 32'h0000_0081, 32'hA5A5_0F0F};
    vecs[5] = '{1'b0, 7'h00, 32'hFFFF_FFFF, 8'h81, 32'h0,         32'hA5A5_0F0F};
    vecs[6] = '{1'b1, 7'h00, 32'h0,         8'h81, 32'h1911_0100, 32'hA5A5_0F0F};
    vecs[7] = '{1'b1, 7'h7F, 32'h0,         8'h81, 32'hDEAD_BEEF, 32'hA5A5_0F0F};
    vecs[8] = '{1'b0, 7'h03, 32'hCAFE_0001, 8'h3C, 32'h0,         32'hA5A5_0F0F};
    vecs[9] = '{1'b1, 7'h03, 32'h0,         8'h3C, 32'hCAFE_0001, 32'hA5A5_0F0F};

    // Reset state.
    repeat (5) @(negedge clk);
    check("rst_miso",    {31'h0, spi_miso}, 32'h0);
    check("rst_ctrl",    ctrl, P_CRST);
    check("rst_wr_stb",  {31'h0, wr_stb}, 32'h0);
    check("rst_wr_addr", {25'h0, wr_addr}, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write to scratch aborted after 20 data bits, then read back.
    s0 = stb_cnt;
    spi_xfer(1'b0, 7'h03, 32'h1234_5678, 28, NO_RST, 1'b0, rd);
    check("abort_no_stb", 32'(stb_cnt - s0), 32'h0);
    spi_xfer(1'b1, 7'h03, 32'h0, 40, NO_RST, 1'b0, rd);
    m_fcnt++;
    check("abort_scratch_rd", rd, 32'h0);

    // Table of complete frames.
    for (int unsigned i = 0; i < 10; i++) begin
      dipsw = vecs[i].dip;
      s0 = stb_cnt;
      spi_xfer(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 40, NO_RST, 1'b0, rd);
      m_fcnt++;
      if (vecs[i].rw) begin
        check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        check($sformatf("vec%0d_no_stb", i), 32'(stb_cnt - s0), 32'h0);
      end else begin
        model_wr(vecs[i].addr, vecs[i].wdata);
        check($sformatf("vec%0d_stb", i), 32'(stb_cnt - s0), 32'h1);
        check($sformatf("vec%0d_wr_addr", i), {25'h0, last_addr}, {25'h0, vecs[i].addr});
        check($sformatf("vec%0d_wr_data", i), last_data, vecs[i].wdata);
      end
      check($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].exp_ctrl);
    end

    // NSS rising together with the 40th SCK rise still commits.
    s0 = stb_cnt;
    spi_xfer(1'b0, 7'h04, 32'h0000_00C3, 40, NO_RST, 1'b1, rd);
    m_fcnt++;
    model_wr(7'h04, 32'h0000_00C3);
    check("nss_last_stb", 32'(stb_cnt - s0), 32'h1);
    check("nss_last_ctrl", ctrl, 32'h0000_00C3);

    // Reset during data bit 30 of a write to ctrl.
    s0 = stb_cnt;
    spi_xfer(1'b0, 7'h04, 32'h0000_0001, 40, 38, 1'b0, rd);
    m_ctrl = P_CRST; m_scratch = '0; m_fcnt = '0;
    check("midrst_ctrl", ctrl, P_CRST);
    check("midrst_no_stb", 32'(stb_cnt - s0), 32'h0);
    spi_xfer(1'b1, 7'h01, 32'h0, 40, NO_RST, 1'b0, rd);
    m_fcnt++;
    check("midrst_rd_ver", rd, {24'h0, P_VER});

    // Three complete frames, one aborted, then the frame counter address.
    spi_xfer(1'b0, 7'h03, 32'h0BAD_F00D, 40, NO_RST, 1'b0, rd);
    m_fcnt++;
    model_wr(7'h03, 32'h0BAD_F00D);
    spi_xfer(1'b1, 7'h03, 32'h0, 40, NO_RST, 1'b0, rd);
    m_fcnt++;
    check("fcnt_scratch_rd", rd, 32'h0BAD_F00D);
    spi_xfer(1'b1, 7'h00, 32'h0, 17, NO_RST, 1'b0, rd);
    spi_xfer(1'b1, 7'h05, 32'h0, 40, NO_RST, 1'b0, rd);
    check("fcnt_rd", rd, FCNT_EN ? 32'd3 : 32'hDEAD_BEEF);
    m_fcnt++;

    // Randomized frames against the model.
    for (int unsigned k = 0; k < 24; k++) begin
      bit          rw;
      bit          abort;
      logic [6:0]  a;
      logic [31:0] wd, exp;
      int unsigned nb;
      rw    = 1'($urandom_range(0, 1));
      a     = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
      wd    = $urandom;
      dipsw = 8'($urandom);
      abort = ($urandom_range(0, 5) == 0);
      nb    = abort ? $urandom_range(1, 39) : 40;
      exp   = model_rd(a);
      s0    = stb_cnt;
      spi_xfer(rw, a, wd, nb, NO_RST, 1'b0, rd);
      if (abort) begin
        check($sformatf("rnd%0d_abort_no_stb", k), 32'(stb_cnt - s0), 32'h0);
      end else if (rw) begin
        m_fcnt++;
        check($sformatf("rnd%0d_rd_a%0h", k, a), rd, exp);
        check($sformatf("rnd%0d_no_stb", k), 32'(stb_cnt - s0), 32'h0);
      end else begin
        m_fcnt++;
        model_wr(a, wd);
        check($sformatf("rnd%0d_stb", k), 32'(stb_cnt - s0), 32'h1);
        check($sformatf("rnd%0d_wr_addr", k), {25'h0, last_addr}, {25'h0, a});
        check($sformatf("rnd%0d_wr_data", k), last_data, wd);
      end
      check($sformatf("rnd%0d_ctrl", k), ctrl, m_ctrl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
